// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit buffer: drain FSM states,
// status-byte bit positions and uart register addresses.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      SAMPLE,
      WRITE,
      SETTLE
   } drain_state_e;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_BUSY  = 3;
   localparam int ST_LOW   = 4;

   localparam logic UART_REG_DATA   = 1'b0;
   localparam logic UART_REG_STATUS = 1'b1;

   // Low-water threshold in bytes: a quarter of the FIFO depth.
   function automatic int low_water(input int depth_log2);
      return (1 << depth_log2) / 4;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: storage, wrapping pointers, occupancy count and
// full/empty flags. Pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  push_ok;
   logic                  pop_ok;

   always_comb begin
      full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
      empty   = (count_q == '0);
      // Full and empty are judged on the pre-update count, so a push into a
      // full FIFO is rejected even when a pop happens on the same edge.
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      wptr_d  = push_ok ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
      rptr_d  = pop_ok  ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-facing transmit buffer that drains bytes into the uart data register
// whenever the uart reports tx idle. Optional low-water interrupt: UART_TX_FIFO_LOWWATER_INT_EN.
//
// state  | meaning
// IDLE   | waiting for the FIFO to hold at least one byte
// POLL   | read strobe on the uart status register
// SAMPLE | uart status returned; decide re-poll or write
// WRITE  | write strobe with the head byte; head is popped at the end of this cycle
// SETTLE | bus quiet for one cycle so the uart can raise tx active
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2    = 4,
   parameter int TX_ACTIVE_BIT = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_dat,
   output logic [7:0] o_dat,
   input  logic       i_addr,
   input  logic       i_we,
   input  logic       i_cyc,
   output logic       o_int,
   output logic [7:0] o_m_dat,
   input  logic [7:0] i_m_dat,
   output logic       o_m_addr,
   output logic       o_m_we,
   output logic       o_m_cyc
);

   drain_state_e        state_q, state_d;
   logic                m_cyc_q, m_cyc_d;
   logic                m_we_q, m_we_d;
   logic                m_addr_q, m_addr_d;
   logic [7:0]          m_dat_q, m_dat_d;
   logic                ovf_q, ovf_d;

   logic                push_req;
   logic                status_rd;
   logic                fifo_pop;
   logic [7:0]          fifo_rdata;
   logic [DEPTH_LOG2:0] fifo_count;
   logic                fifo_full;
   logic                fifo_empty;
   logic [7:0]          status;

   assign push_req  = i_cyc & i_we & ~i_addr;
   assign status_rd = i_cyc & ~i_we & i_addr;

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (8)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_reset),
      .push  (push_req),
      .pop   (fifo_pop),
      .wdata (i_dat),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A read of status clears overflow, but an overflow on the same edge wins.
   assign ovf_d = (ovf_q & ~status_rd) | (push_req & fifo_full);

   always_comb begin
      state_d  = state_q;
      m_cyc_d  = 1'b0;
      m_we_d   = 1'b0;
      m_addr_d = m_addr_q;
      m_dat_d  = m_dat_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_count != '0) begin
               state_d  = POLL;
               m_cyc_d  = 1'b1;
               m_addr_d = UART_REG_STATUS;
            end
         end
         POLL: begin
            state_d = SAMPLE;
         end
         SAMPLE: begin
            if (i_m_dat[TX_ACTIVE_BIT]) begin
               state_d  = POLL;
               m_cyc_d  = 1'b1;
               m_addr_d = UART_REG_STATUS;
            end else begin
               state_d  = WRITE;
               m_cyc_d  = 1'b1;
               m_we_d   = 1'b1;
               m_addr_d = UART_REG_DATA;
               m_dat_d  = fifo_rdata;
            end
         end
         WRITE: begin
            fifo_pop = 1'b1;
            state_d  = SETTLE;
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= IDLE;
         m_cyc_q  <= 1'b0;
         m_we_q   <= 1'b0;
         m_addr_q <= 1'b0;
         m_dat_q  <= 8'h00;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_cyc_q  <= m_cyc_d;
         m_we_q   <= m_we_d;
         m_addr_q <= m_addr_d;
         m_dat_q  <= m_dat_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef UART_TX_FIFO_LOWWATER_INT_EN
   logic low_q, low_d;

   assign low_d = (fifo_count <= (DEPTH_LOG2+1)'(low_water(DEPTH_LOG2)));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) low_q <= 1'b1;
      else          low_q <= low_d;
   end

   assign o_int = low_q;
`else
   assign o_int = fifo_empty;
`endif

   always_comb begin
      status           = 8'h00;
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_OVF]   = ovf_q;
      status[ST_BUSY]  = (state_q != IDLE);
`ifdef UART_TX_FIFO_LOWWATER_INT_EN
      status[ST_LOW]   = low_q;
`endif
   end

   assign o_dat    = status;
   assign o_m_cyc  = m_cyc_q;
   assign o_m_we   = m_we_q;
   assign o_m_addr = m_addr_q;
   assign o_m_dat  = m_dat_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small uart register model that
// returns status one cycle after a poll and records every write strobe.
module tb_uart_tx_fifo;

   localparam int DEPTH_LOG2 = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cpu_wdat;
   logic [7:0] cpu_rdat;
   logic       cpu_addr;
   logic       cpu_we;
   logic       cpu_cyc;
   logic       irq;
   logic [7:0] m_dat_o;
   logic [7:0] m_dat_i;
   logic       m_addr;
   logic       m_we;
   logic       m_cyc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DEPTH_LOG2    (DEPTH_LOG2),
      .TX_ACTIVE_BIT (2)
   ) dut (
      .i_clk    (clk),
      .i_reset  (rst_n),
      .i_dat    (cpu_wdat),
      .o_dat    (cpu_rdat),
      .i_addr   (cpu_addr),
      .i_we     (cpu_we),
      .i_cyc    (cpu_cyc),
      .o_int    (irq),
      .o_m_dat  (m_dat_o),
      .i_m_dat  (m_dat_i),
      .o_m_addr (m_addr),
      .o_m_we   (m_we),
      .o_m_cyc  (m_cyc)
   );

   // uart model: status register read back one cycle after the poll strobe
   logic       uart_busy = 1'b0;
   logic [7:0] uart_rd   = 8'h00;
   assign m_dat_i = uart_rd;

   always @(posedge clk) begin
      if (m_cyc && !m_we && m_addr) uart_rd <= uart_busy ? 8'h04 : 8'h00;
   end

   int         cyc_cnt     = 0;
   int         b2b         = 0;
   int         n_strobes   = 0;
   int         n_polls     = 0;
   logic       prev_cyc    = 1'b0;
   logic       prev_poll   = 1'b0;
   logic [7:0] last_sample = 8'hFF;
   logic [7:0] wr_q [$];
   int         wr_edge [$];
   logic [7:0] wr_smp [$];

   always @(posedge clk) begin
      if (m_cyc && prev_cyc) b2b <= b2b + 1;
      if (prev_poll) last_sample <= m_dat_i;
      if (m_cyc) n_strobes <= n_strobes + 1;
      if (m_cyc && !m_we) n_polls <= n_polls + 1;
      if (m_cyc && m_we) begin
         wr_q.push_back(m_dat_o);
         wr_edge.push_back(cyc_cnt);
         wr_smp.push_back(last_sample);
      end
      prev_cyc  <= m_cyc;
      prev_poll <= m_cyc && !m_we;
      cyc_cnt   <= cyc_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      cpu_cyc  = 1'b0;
      cpu_we   = 1'b0;
      cpu_addr = 1'b0;
      cpu_wdat = 8'h00;
   endtask

   task automatic push(input logic [7:0] b, output int edge_idx);
      @(negedge clk);
      edge_idx = cyc_cnt;
      cpu_cyc  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 1'b0;
      cpu_wdat = b;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic status_rd(input string tag, input logic [7:0] exp);
      @(negedge clk);
      cpu_cyc  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 1'b1;
      #1 chk(tag, cpu_rdat, exp);
      @(negedge clk);
      idle_bus();
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int k = 0;
      while (wr_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, wr_q.size(), n);
   endtask

   task automatic wait_write_cycle(input string tag);
      int  k     = 0;
      bit  found = 1'b0;
      while (!found && k < 60) begin
         @(negedge clk);
         k++;
         if (m_cyc && m_we) found = 1'b1;
      end
      chk(tag, found, 1);
   endtask

   task automatic clear_log();
      wr_q.delete();
      wr_edge.delete();
      wr_smp.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int p_edge;
      int polls_before;
      int strobes_before;

      idle_bus();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_odat", cpu_rdat, 8'h01);
      chk("rst_int", irq, 1);
      chk("rst_mcyc", m_cyc, 0);
      chk("rst_mdat", m_dat_o, 8'h00);
      status_rd("rst_status", 8'h01);
      repeat (20) @(negedge clk);
      chk("idle_strobes", n_strobes, 0);
      chk("idle_int", irq, 1);

      // single byte, uart idle
      clear_log();
      push(8'h41, p_edge);
      wait_writes(1, 20, "single_cnt");
      repeat (5) @(negedge clk);
      chk("single_only", wr_q.size(), 1);
      chk("single_data", wr_q[0], 8'h41);
      chk("single_latency", wr_edge[0] - p_edge, 4);
      status_rd("single_status", 8'h01);
      chk("single_int", irq, 1);

      // three bytes while the uart stays busy
      clear_log();
      uart_busy    = 1'b1;
      polls_before = n_polls;
      push(8'h10, p_edge);
      push(8'h11, p_edge);
      push(8'h12, p_edge);
      repeat (100) @(negedge clk);
      chk("busy_no_write", wr_q.size(), 0);
      chk("busy_polled", (n_polls - polls_before) > 10, 1);
      uart_busy = 1'b0;
      wait_writes(3, 100, "busy_drain_cnt");
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("busy_data%0d", i), wr_q[i], 8'h10 + 8'(i));
         chk($sformatf("busy_poll%0d", i), wr_smp[i], 8'h00);
      end
      repeat (6) @(negedge clk);

      // overflow: 17 pushes into a 16-deep FIFO with the uart busy
      clear_log();
      uart_busy = 1'b1;
      for (int i = 0; i < 17; i++) push(8'h80 + 8'(i), p_edge);
      status_rd("ovf_status", 8'h0E);
      status_rd("ovf_cleared", 8'h0A);
      chk("ovf_int", irq, 0);

      // push into a full FIFO on the same edge as the WRITE pop
      uart_busy = 1'b0;
      wait_write_cycle("coll_found");
      cpu_cyc  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 1'b0;
      cpu_wdat = 8'hAA;
      @(negedge clk);
      cpu_we   = 1'b0;
      cpu_addr = 1'b1;
      #1 chk("coll_status", cpu_rdat, 8'h0C);
      @(negedge clk);
      idle_bus();
      wait_writes(16, 400, "coll_drain_cnt");
      repeat (10) @(negedge clk);
      chk("coll_drain_total", wr_q.size(), 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("coll_data%0d", i), wr_q[i], 8'h80 + 8'(i));
      status_rd("coll_final", 8'h01);

      // reset asserted in the middle of a WRITE strobe
      clear_log();
      push(8'h55, p_edge);
      wait_write_cycle("rstw_found");
      #1 rst_n = 1'b0;
      #1;
      chk("rstw_mcyc", m_cyc, 0);
      chk("rstw_mwe", m_we, 0);
      @(negedge clk);
      rst_n = 1'b1;
      strobes_before = n_strobes;
      status_rd("rstw_status", 8'h01);
      repeat (30) @(negedge clk);
      chk("rstw_no_strobe", n_strobes - strobes_before, 0);
      chk("rstw_lost", wr_q.size(), 0);

      chk("no_back_to_back", b2b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit buffer and bus master between the CPU data bus and the uart peripheral's register port.
- The CPU writes bytes into a FIFO without polling.
- A drain FSM reads the uart status register. When the uart reports tx idle, the FSM writes the FIFO head byte into the uart transmit register.
- The block replaces direct CPU access to the uart tx path. The uart rx path stays on its own bus decode.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (legal range 2..8)
- TX_ACTIVE_BIT, 2, bit of the uart status byte that means "tx active"

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_dat  in  8  CPU write data
- o_dat  out  8  CPU read data
- i_addr  in  1  0 = data (write-only), 1 = status (read-only)
- i_we  in  1  CPU write enable
- i_cyc  in  1  CPU cycle strobe, one cycle per access
- o_int  out  1  interrupt to CPU
- o_m_dat  out  8  byte to the uart i_dat
- i_m_dat  in  8  uart o_dat
- o_m_addr  out  1  uart i_addr
- o_m_we  out  1  uart i_we
- o_m_cyc  out  1  uart i_cyc

Behaviour:
- Reset (i_reset low, asynchronous), all state returns to reset values:
  - pointers = 0, count = 0, overflow = 0, FSM = IDLE
  - o_m_cyc = 0, o_m_we = 0, o_m_addr = 0, o_m_dat = 0
  - o_int = 1 (FIFO empty), o_dat = 0x01
- Count width is DEPTH_LOG2+1. Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
- CPU push: i_cyc & i_we & ~i_addr.
  - If not full, the byte is stored at wptr and wptr advances.
  - If full, the byte is dropped and overflow is set (sticky).
- CPU status read: i_cyc & ~i_we & i_addr.
  - o_dat = {4'b0, busy, overflow, full, empty}, where busy = FSM not IDLE.
  - Overflow clears on the cycle after the read. If an overflow happens in the same cycle as the read, overflow stays set.
- o_dat is combinational from current state. For any access that is not a status read, o_dat = the status byte anyway.
- CPU write with i_addr = 1 is ignored. CPU read with i_addr = 0 returns the status byte.
- Drain FSM, registered outputs:
  - IDLE: if count != 0, go to POLL.
  - POLL: o_m_cyc = 1, o_m_we = 0, o_m_addr = 1, held for one cycle. Next cycle i_m_dat is sampled.
    - If bit TX_ACTIVE_BIT = 1, go to POLL again (re-poll).
    - Otherwise go to WRITE.
  - WRITE: o_m_cyc = 1, o_m_we = 1, o_m_addr = 0, o_m_dat = fifo[rptr], for exactly one cycle. The pop happens (rptr++, count--) in this cycle. Then go to SETTLE.
  - SETTLE: o_m_cyc = 0 for one cycle, so the uart sets tx active. Then go to IDLE.
- Latency: a push into an empty FIFO with the uart idle gives the uart write strobe 4 cycles later (IDLE, POLL, sample, WRITE).
- Simultaneous push and pop in the WRITE cycle:
  - Both take effect and count is unchanged.
  - Full plus simultaneous pop: the push is still rejected. Full is evaluated before the pop.
- o_m_cyc is never asserted on two consecutive cycles except back-to-back POLLs, which are separated by the sample cycle (POLL strobe, then idle sample cycle).
- o_int = empty (level), unless the optional feature is enabled.
- Reset mid-WRITE: the strobe drops asynchronously and the byte is lost. This is acceptable.

Optional Feature:
- Macro: UART_TX_FIFO_LOWWATER_INT_EN
- Defined:
  - o_int = (count <= 2**DEPTH_LOG2/4) registered, so it asserts one cycle after count drops to the threshold.
  - Status bit 4 = low-water flag.
- Undefined:
  - o_int = empty, combinational.
  - Status bit 4 = 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum {IDLE, POLL, SAMPLE, WRITE, SETTLE}
  - Status bit index constants: ST_EMPTY = 0, ST_FULL = 1, ST_OVF = 2, ST_BUSY = 3, ST_LOW = 4
  - Uart register addresses: UART_REG_DATA = 0, UART_REG_STATUS = 1
- One sub-module, sync_fifo:
  - Parameterised storage, pointers, count, full and empty.
  - The drain FSM and bus logic stay in uart_tx_fifo.

Test Plan:
- Reset, then a status read -> o_dat = 0x01, o_int = 1, o_m_cyc = 0 for 20 cycles.
- Push 0x41 with a uart model reporting status 0x00 -> exactly one write strobe with o_m_dat = 0x41, 4 cycles after the push. Afterwards empty = 1 and o_int = 1.
- Push 0x10, 0x11, 0x12 while the model holds tx active for 100 cycles -> only POLL strobes occur during the busy time, then three writes in order 0x10, 0x11, 0x12, each preceded by a POLL that sees status 0x00.
- With DEPTH_LOG2 = 4 and the uart held busy, push 17 bytes -> status = 0x0E (busy, ovf, full). Byte 17 is absent from the drained stream. A second status read after the first shows ovf = 0.
- Full FIFO, push in the same cycle as the WRITE pop -> push rejected, count = 15 after that cycle, overflow = 1.
- Assert i_reset low during WRITE -> o_m_cyc = 0 immediately (asynchronous). After release, status = 0x01 and no further strobes occur.
